piso_bit_feeder: RTL and testbench
==================================

# piso_bit_feeder

Parallel-in/serial-out bit source that sits directly upstream of the Mealy 11010 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them, one bit per clock, onto the detector's `in_bit` input, with a `bit_valid` qualifier. Back-to-back words stream with no gap cycle. An accepted-word counter supports debug and coverage.

## Interface
- `WIDTH`, 8: word width in bits; legal range ≥1.
- `MSB_FIRST`, 1: 1 = shift MSB first; 0 = shift LSB first.
- `COUNT_W`, 16: width of `word_count`.

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `load_data`  in  WIDTH: word to serialize.
- `load_valid`  in  1: `load_data` is valid.
- `load_ready`  out  1: block can accept a word this cycle.
- `in_bit`  out  1: serial bit to the detector (registered).
- `bit_valid`  out  1: `in_bit` carries a payload bit this cycle (registered).
- `busy`  out  1: state is SHIFT.
- `word_count`  out  COUNT_W: number of accepted words, modulo 2^COUNT_W.

## Operation
- States: IDLE and SHIFT. Registers:
  - `shreg[WIDTH-1:0]`
  - `bcnt`, ceil(log2(WIDTH)) bits, minimum 1 bit
  - `in_bit`, `bit_valid`, `word_count`
- Accept rule: accept = `load_valid` && `load_ready`. This is the only event that captures `load_data`.
- `load_ready` is combinational: 1 in IDLE, or in SHIFT with `bcnt`==0 (last bit on the line). It is 0 in every other cycle.
- IDLE:
  - `in_bit`=0, `bit_valid`=0.
  - On accept: `shreg` ← `load_data`, `bcnt` ← WIDTH-1, `word_count`+1, then go to SHIFT.
- SHIFT:
  - Each cycle, `in_bit` shows the current head bit: `shreg[WIDTH-1]` if MSB_FIRST, else `shreg[0]`. `bit_valid`=1.
  - Each edge with `bcnt`≠0: shift `shreg` toward the head by one (zero-fill) and decrement `bcnt`.
  - Edge with `bcnt`==0 and accept: reload as in IDLE and stay in SHIFT (gapless).
  - Edge with `bcnt`==0 and no accept: go to IDLE.
- `load_valid` in a non-ready cycle is ignored. The producer must hold `load_data` and `load_valid` until accepted.
- `word_count` wraps from 2^COUNT_W-1 to 0 and never saturates.
- WIDTH=1: every SHIFT cycle is a last-bit cycle, so `load_ready` stays 1 throughout.
- Reset asserted at any time, including mid-word: all registers clear immediately. The word in flight is discarded without completing. A detector sharing `reset` clears in the same way.

## Timing
- Reset values:
  - state=IDLE, `shreg`=0, `bcnt`=0, `in_bit`=0, `bit_valid`=0, `word_count`=0, `busy`=0.
  - `load_ready`=1 after release. No capture occurs while `reset` is high.
- Latency: for a word accepted at edge k, bit i (i = 0..WIDTH-1, in shift order) is on `in_bit` between edges k+i and k+i+1. The detector samples bit i at edge k+i+1.
- Throughput: one bit per clock. A word accepted in the last-bit cycle continues the stream with zero idle cycles.
- After the last bit with no new word: `bit_valid` falls at edge k+WIDTH and `in_bit` returns to 0.
- `busy` equals (state==SHIFT) and is registered.

## Structure
- Shared package/header holds:
  - state encodings `ST_IDLE`=1'b0 and `ST_SHIFT`=1'b1
  - the `clog2`-based counter-width helper
- Single module; no sub-module is needed.
- The top level instantiates `piso_bit_feeder` → Mealy 11010 detector:
  - `in_bit` connects to `in_bit`
  - `clk` and `reset` are shared
  - `bit_valid` is available to gate the detector's output

## Test plan
- Reset, then WIDTH=8, MSB_FIRST=1, load 8'b1101_0000 → `in_bit` = 1,1,0,1,0,0,0,0 on 8 consecutive cycles, `bit_valid`=1 for exactly 8 cycles. The downstream detector pulses `out` while the 5th bit (0) is on the line.
- Back-to-back: `load_valid` held high with 8'hD6 then 8'h5A → 16 contiguous valid bits 11010110_01011010. `load_ready` is high only in cycles 0, 8 and 16. `word_count`=2.
- MSB_FIRST=0, load 8'h0B → `in_bit` = 1,1,0,1,0,0,0,0 (LSB first). The detector fires on the 5th bit.
- `load_valid` asserted with 8'hFF during bits 2–5 of a word in flight → no capture until the last-bit cycle. Then 8'hFF streams with no gap. Data stays unchanged while stalled.
- Assert `reset` during the 4th bit of 8'hD0 → `in_bit`, `bit_valid`, `busy` and `word_count` read 0 immediately. After release, a new 8'hD0 serializes cleanly from bit 0.
- COUNT_W=2, accept 5 words → `word_count` sequence is 1,2,3,0,1.

Source files
------------

// File: rtl/piso_bit_feeder_pkg.sv
// ---------------------------------------------------------------------------
// piso_bit_feeder_pkg
// Shared definitions for the parallel-in/serial-out bit feeder.
//   state_t    : FSM state encoding (ST_IDLE = 0, ST_SHIFT = 1)
//   bcnt_width : width of the remaining-bits counter for a given word width,
//                never less than one bit so WIDTH=1 still has a real register
// ---------------------------------------------------------------------------
package piso_bit_feeder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // ceil(log2(w)) with a floor of 1 bit.
  function automatic int bcnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_feeder_if.sv
// ---------------------------------------------------------------------------
// piso_bit_feeder_if
// Valid/ready word-load channel into the bit feeder.
//   load_data  : word to serialize (producer -> feeder)
//   load_valid : load_data is valid (producer -> feeder)
//   load_ready : feeder can take a word this cycle (feeder -> producer)
// Modports:
//   master : the word producer
//   slave  : the feeder
// WIDTH must match the WIDTH of the piso_bit_feeder it is bound to.
// ---------------------------------------------------------------------------
interface piso_bit_feeder_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/piso_bit_feeder.sv
// ---------------------------------------------------------------------------
// piso_bit_feeder
// Accepts WIDTH-bit words over a valid/ready channel and plays them out one
// bit per clock on in_bit (qualified by bit_valid), feeding the 11010
// sequence detector. A word offered during the last-bit cycle is taken
// immediately, so consecutive words stream with no gap.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset, clears everything
//   load_if    : word load channel (slave side)
//   in_bit     : registered serial bit
//   bit_valid  : registered qualifier, 1 while a payload bit is on in_bit
//   busy       : 1 while the FSM is in SHIFT
//   word_count : accepted words, wraps modulo 2^COUNT_W
// ---------------------------------------------------------------------------
module piso_bit_feeder
  import piso_bit_feeder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  piso_bit_feeder_if.slave   load_if,
  output logic               in_bit,
  output logic               bit_valid,
  output logic               busy,
  output logic [COUNT_W-1:0] word_count
);

  localparam int             CNT_W    = bcnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   shreg, shreg_nx;
  logic [CNT_W-1:0]   bcnt, bcnt_nx;
  logic [COUNT_W-1:0] word_count_nx;
  logic               in_bit_nx;
  logic               bit_valid_nx;
  logic               accept;

  // The bit that goes on the line next, given a shift-register image.
  function automatic logic head_of(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Move the register one place toward the head, zero-filling the tail.
  function automatic logic [WIDTH-1:0] shift_toward_head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  // bcnt is zero both in IDLE and while the last bit of a word is on the
  // line, which is exactly when a new word may be taken.
  assign load_if.load_ready = (state == ST_IDLE) || (bcnt == '0);
  assign accept             = load_if.load_valid && load_if.load_ready;
  assign busy               = (state == ST_SHIFT);

  // Next-state and datapath. in_bit/bit_valid are computed from the next
  // state so they land in their flops on the same edge as the word, giving
  // bit 0 on the line in the cycle right after the accept.
  always_comb begin
    state_nx      = state;
    shreg_nx      = shreg;
    bcnt_nx       = bcnt;
    word_count_nx = word_count;

    if (accept) begin
      shreg_nx      = load_if.load_data;
      bcnt_nx       = LAST_IDX;
      word_count_nx = word_count + COUNT_W'(1);
      state_nx      = ST_SHIFT;
    end else if (state == ST_SHIFT) begin
      if (bcnt != '0) begin
        shreg_nx = shift_toward_head(shreg);
        bcnt_nx  = bcnt - CNT_W'(1);
      end else begin
        shreg_nx = '0;
        state_nx = ST_IDLE;
      end
    end

    bit_valid_nx = (state_nx == ST_SHIFT);
    in_bit_nx    = bit_valid_nx ? head_of(shreg_nx) : 1'b0;
  end

  // State and datapath registers; reset drops the word in flight at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bcnt       <= '0;
      in_bit     <= 1'b0;
      bit_valid  <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      bcnt       <= bcnt_nx;
      in_bit     <= in_bit_nx;
      bit_valid  <= bit_valid_nx;
      word_count <= word_count_nx;
    end
  end

endmodule

// File: tb/tb_piso_bit_feeder.sv
// ---------------------------------------------------------------------------
// tb_piso_bit_feeder
// Directed bench for piso_bit_feeder. Four instances share clk/reset:
//   dut_a : WIDTH=8, MSB first, COUNT_W=16
//   dut_b : WIDTH=8, LSB first
//   dut_c : WIDTH=2, COUNT_W=2 (counter wrap)
//   dut_d : WIDTH=1 (every cycle is a last-bit cycle)
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_piso_bit_feeder;

  logic clk;
  logic reset;

  int checks;
  int errors;

  piso_bit_feeder_if #(.WIDTH(8)) a_if ();
  piso_bit_feeder_if #(.WIDTH(8)) b_if ();
  piso_bit_feeder_if #(.WIDTH(2)) c_if ();
  piso_bit_feeder_if #(.WIDTH(1)) d_if ();

  logic        a_in_bit, a_bit_valid, a_busy;
  logic [15:0] a_word_count;
  logic        b_in_bit, b_bit_valid, b_busy;
  logic [15:0] b_word_count;
  logic        c_in_bit, c_bit_valid, c_busy;
  logic [1:0]  c_word_count;
  logic        d_in_bit, d_bit_valid, d_busy;
  logic [15:0] d_word_count;

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .COUNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .load_if(a_if.slave),
    .in_bit(a_in_bit), .bit_valid(a_bit_valid), .busy(a_busy),
    .word_count(a_word_count)
  );

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .COUNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .load_if(b_if.slave),
    .in_bit(b_in_bit), .bit_valid(b_bit_valid), .busy(b_busy),
    .word_count(b_word_count)
  );

  piso_bit_feeder #(.WIDTH(2), .MSB_FIRST(1'b1), .COUNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .load_if(c_if.slave),
    .in_bit(c_in_bit), .bit_valid(c_bit_valid), .busy(c_busy),
    .word_count(c_word_count)
  );

  piso_bit_feeder #(.WIDTH(1), .MSB_FIRST(1'b1), .COUNT_W(16)) dut_d (
    .clk(clk), .reset(reset), .load_if(d_if.slave),
    .in_bit(d_in_bit), .bit_valid(d_bit_valid), .busy(d_busy),
    .word_count(d_word_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    logic [7:0]  seq_d0;
    logic [15:0] seq_bb;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    a_if.load_valid = 1'b0; a_if.load_data = '0;
    b_if.load_valid = 1'b0; b_if.load_data = '0;
    c_if.load_valid = 1'b0; c_if.load_data = '0;
    d_if.load_valid = 1'b0; d_if.load_data = '0;

    // Shift-order bit sequence expected for 8'hD0 MSB first and 8'h0B LSB first.
    seq_d0 = 8'b1101_0000;
    // 8'hD6 followed by 8'h5A, MSB first.
    seq_bb = 16'b11010110_01011010;

    @(negedge clk);
    apply_reset();

    // --- Reset values
    $display("[TB] reset values");
    check_output("rst_in_bit",     a_in_bit,     0);
    check_output("rst_bit_valid",  a_bit_valid,  0);
    check_output("rst_busy",       a_busy,       0);
    check_output("rst_word_count", a_word_count, 0);
    check_output("rst_load_ready", a_if.load_ready, 1);

    // --- Single word 8'hD0, MSB first
    $display("[TB] single word D0 msb first");
    a_if.load_data  = 8'hD0;
    a_if.load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_if.load_valid = 1'b0;
      check_output($sformatf("d0_bit%0d", i),   a_in_bit,        seq_d0[7-i]);
      check_output($sformatf("d0_valid%0d", i), a_bit_valid,     1);
      check_output($sformatf("d0_busy%0d", i),  a_busy,          1);
      check_output($sformatf("d0_ready%0d", i), a_if.load_ready, (i == 7));
    end
    @(negedge clk);
    check_output("d0_end_valid", a_bit_valid,  0);
    check_output("d0_end_bit",   a_in_bit,     0);
    check_output("d0_end_busy",  a_busy,       0);
    check_output("d0_count",     a_word_count, 1);

    // --- Back-to-back D6 then 5A
    $display("[TB] back-to-back D6 5A");
    apply_reset();
    for (int c = 0; c <= 16; c++) begin
      if (c == 0) begin
        a_if.load_data  = 8'hD6;
        a_if.load_valid = 1'b1;
      end else begin
        check_output($sformatf("bb_bit%0d", c),   a_in_bit,    seq_bb[16-c]);
        check_output($sformatf("bb_valid%0d", c), a_bit_valid, 1);
      end
      check_output($sformatf("bb_ready%0d", c), a_if.load_ready,
                   (c == 0 || c == 8 || c == 16));
      if (c == 1) a_if.load_data = 8'h5A;
      if (c == 9) a_if.load_valid = 1'b0;
      @(negedge clk);
    end
    check_output("bb_end_valid", a_bit_valid,  0);
    check_output("bb_count",     a_word_count, 2);

    // --- LSB first, 8'h0B
    $display("[TB] lsb first 0B");
    apply_reset();
    b_if.load_data  = 8'h0B;
    b_if.load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_if.load_valid = 1'b0;
      check_output($sformatf("lsb_bit%0d", i),   b_in_bit,    seq_d0[7-i]);
      check_output($sformatf("lsb_valid%0d", i), b_bit_valid, 1);
    end
    @(negedge clk);
    check_output("lsb_end_valid", b_bit_valid,  0);
    check_output("lsb_count",     b_word_count, 1);

    // --- Stall: FF offered from bit 2 of D0, taken at the last-bit cycle
    $display("[TB] stalled load");
    apply_reset();
    a_if.load_data  = 8'hD0;
    a_if.load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) a_if.load_valid = 1'b0;
      check_output($sformatf("st_bit%0d", i),   a_in_bit,
                   (i < 8) ? seq_d0[7-i] : 1'b1);
      check_output($sformatf("st_ready%0d", i), a_if.load_ready, (i == 7 || i == 15));
      check_output($sformatf("st_count%0d", i), a_word_count, (i < 8) ? 1 : 2);
      if (i == 2) begin
        a_if.load_data  = 8'hFF;
        a_if.load_valid = 1'b1;
      end
      if (i == 8) a_if.load_valid = 1'b0;
    end
    @(negedge clk);
    check_output("st_end_valid", a_bit_valid, 0);

    // --- Reset during the 4th bit, then a clean reload
    $display("[TB] reset mid-word");
    apply_reset();
    a_if.load_data  = 8'hD0;
    a_if.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_if.load_valid = 1'b0;
      check_output($sformatf("mr_bit%0d", i), a_in_bit, seq_d0[7-i]);
    end
    reset = 1'b1;
    #1;
    check_output("mr_in_bit",     a_in_bit,     0);
    check_output("mr_bit_valid",  a_bit_valid,  0);
    check_output("mr_busy",       a_busy,       0);
    check_output("mr_word_count", a_word_count, 0);
    @(negedge clk);
    reset = 1'b0;
    check_output("mr_ready_after", a_if.load_ready, 1);
    a_if.load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_if.load_valid = 1'b0;
      check_output($sformatf("mr2_bit%0d", i), a_in_bit,    seq_d0[7-i]);
      check_output($sformatf("mr2_vld%0d", i), a_bit_valid, 1);
    end
    @(negedge clk);
    check_output("mr2_count", a_word_count, 1);

    // --- COUNT_W=2 wrap over five gapless words
    $display("[TB] word count wrap");
    apply_reset();
    c_if.load_data  = 2'b10;
    c_if.load_valid = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check_output($sformatf("wc_count%0d", j), c_word_count, j % 4);
      check_output($sformatf("wc_valid%0d", j), c_bit_valid, 1);
      check_output($sformatf("wc_bit%0d", j),   c_in_bit,    1);
      @(negedge clk);
      check_output($sformatf("wc_ready%0d", j), c_if.load_ready, 1);
      check_output($sformatf("wc_tail%0d", j),  c_in_bit,        0);
      if (j == 5) c_if.load_valid = 1'b0;
    end
    @(negedge clk);
    check_output("wc_end_valid", c_bit_valid, 0);

    // --- WIDTH=1 stream 1,0,1 with ready held high
    $display("[TB] width one");
    apply_reset();
    d_if.load_data  = 1'b1;
    d_if.load_valid = 1'b1;
    @(negedge clk);
    check_output("w1_bit0",   d_in_bit,        1);
    check_output("w1_ready0", d_if.load_ready, 1);
    d_if.load_data = 1'b0;
    @(negedge clk);
    check_output("w1_bit1",   d_in_bit,        0);
    check_output("w1_valid1", d_bit_valid,     1);
    check_output("w1_ready1", d_if.load_ready, 1);
    d_if.load_data = 1'b1;
    @(negedge clk);
    check_output("w1_bit2",   d_in_bit,        1);
    check_output("w1_ready2", d_if.load_ready, 1);
    d_if.load_valid = 1'b0;
    @(negedge clk);
    check_output("w1_end_valid", d_bit_valid,  0);
    check_output("w1_end_busy",  d_busy,       0);
    check_output("w1_count",     d_word_count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
